mips_mem_pipe: RTL and testbench

MIPS_MEM_PIPE -- requirements
Module: mips_mem_pipe

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/mips_mem_rdpipe.sv | 60 ++++++
 rtl/mips_mem_pipe.sv | 121 ++++++++++++
 tb/tb_mips_mem_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared widths, latency bounds and segment decode for the dual-port MIPS data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam int WORD_W  = 32;
    localparam int BE_W    = WORD_W / 8;
    localparam int ADDR_W  = 30;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    // A word address is mapped when every bit above the index field matches the base.
    function automatic logic in_seg(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int depth_log2);
        return (addr >> depth_log2) == (base >> depth_log2);
    endfunction

endpackage

// File: rtl/mips_mem_rdpipe.sv
// Delay line carrying a read response {valid, excpt, data} through STAGES resettable stages.
// Latency: STAGES cycles (0 = combinational pass-through).
// Backpressure: none; one response may enter every cycle.
module mips_mem_rdpipe
    import mips_mem_pkg::*;
#(
    parameter int STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic              in_exc,
    input  logic [WORD_W-1:0] in_dat,
    output logic              out_vld,
    output logic              out_exc,
    output logic [WORD_W-1:0] out_dat
);

    if (STAGES == 0) begin : g_bypass
        wire unused_ok = ^{clk, rst};
        assign out_vld = in_vld;
        assign out_exc = in_exc;
        assign out_dat = in_dat;
    end else begin : g_pipe
        logic [STAGES-1:0] vld_q, vld_d;
        logic [STAGES-1:0] exc_q, exc_d;
        logic [WORD_W-1:0] dat_q [STAGES];
        logic [WORD_W-1:0] dat_d [STAGES];

        always_comb begin
            vld_d    = '0;
            exc_d    = '0;
            vld_d[0] = in_vld;
            exc_d[0] = in_exc;
            dat_d[0] = in_dat;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                exc_d[i] = exc_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                exc_q <= '0;
                for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
            end else begin
                vld_q <= vld_d;
                exc_q <= exc_d;
                for (int i = 0; i < STAGES; i++) dat_q[i] <= dat_d[i];
            end
        end

        assign out_vld = vld_q[STAGES-1];
        assign out_exc = exc_q[STAGES-1];
        assign out_dat = dat_q[STAGES-1];
    end

endmodule

// File: rtl/mips_mem_pipe.sv
// Dual-port word memory: port 1 read-only, port 2 read plus byte-masked write (read-before-write).
// Latency: LATENCY cycles request-to-valid on both ports; MIPS_MEM_FWD_EN selects write-first port-1 collisions.
// Backpressure: none; each port accepts a request every cycle and responds in order.
module mips_mem_pipe
    import mips_mem_pkg::*;
#(
    parameter int              DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_WADDR = 30'h0,
    parameter int              LATENCY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              valid1,
    output logic [WORD_W-1:0] data_out1,
    output logic              excpt1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [WORD_W-1:0] data_in2,
    input  logic [BE_W-1:0]   we2,
    output logic              valid2,
    output logic [WORD_W-1:0] data_out2,
    output logic              excpt2
);

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DEPTH - 1);

    if (DEPTH_LOG2 < 8 || DEPTH_LOG2 > 16) begin : g_bad_depth
        $error("mips_mem_pipe: DEPTH_LOG2 out of range 8..16");
    end
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_lat
        $error("mips_mem_pipe: LATENCY out of range 1..4");
    end
    if ((BASE_WADDR & ALIGN_MASK) != '0) begin : g_bad_base
        $error("mips_mem_pipe: BASE_WADDR not aligned to the segment size");
    end

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] idx1, idx2;
    logic                  hit1, hit2, wr_en;
    logic [WORD_W-1:0]     rd1_word;

    logic              s0_vld1_q, s0_vld1_d, s0_exc1_q, s0_exc1_d;
    logic              s0_vld2_q, s0_vld2_d, s0_exc2_q, s0_exc2_d;
    logic [WORD_W-1:0] s0_dat1_q, s0_dat1_d, s0_dat2_q, s0_dat2_d;

    always_comb begin
        idx1     = addr1[DEPTH_LOG2-1:0];
        idx2     = addr2[DEPTH_LOG2-1:0];
        hit1     = in_seg(addr1, BASE_WADDR, DEPTH_LOG2);
        hit2     = in_seg(addr2, BASE_WADDR, DEPTH_LOG2);
        wr_en    = req2 && hit2 && (|we2) && !rst;
        rd1_word = mem_q[idx1];
`ifdef MIPS_MEM_FWD_EN
        if (wr_en && idx1 == idx2) begin
            for (int b = 0; b < BE_W; b++) begin
                if (we2[b]) rd1_word[8*b +: 8] = data_in2[8*b +: 8];
            end
        end
`endif
        // Out-of-range and idle slots carry zero data so the outputs need no masking later.
        s0_vld1_d = req1 && !rst;
        s0_exc1_d = req1 && !rst && !hit1;
        s0_dat1_d = (req1 && !rst && hit1) ? rd1_word : '0;
        s0_vld2_d = req2 && !rst;
        s0_exc2_d = req2 && !rst && !hit2;
        s0_dat2_d = (req2 && !rst && hit2) ? mem_q[idx2] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld1_q <= 1'b0;
            s0_exc1_q <= 1'b0;
            s0_dat1_q <= '0;
            s0_vld2_q <= 1'b0;
            s0_exc2_q <= 1'b0;
            s0_dat2_q <= '0;
        end else begin
            s0_vld1_q <= s0_vld1_d;
            s0_exc1_q <= s0_exc1_d;
            s0_dat1_q <= s0_dat1_d;
            s0_vld2_q <= s0_vld2_d;
            s0_exc2_q <= s0_exc2_d;
            s0_dat2_q <= s0_dat2_d;
        end
    end

    // Storage is deliberately not reset; the port-2 read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (we2[b]) mem_q[idx2][8*b +: 8] <= data_in2[8*b +: 8];
            end
        end
    end

    mips_mem_rdpipe #(.STAGES(LATENCY - 1)) u_pipe1 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s0_vld1_q),
        .in_exc  (s0_exc1_q),
        .in_dat  (s0_dat1_q),
        .out_vld (valid1),
        .out_exc (excpt1),
        .out_dat (data_out1)
    );

    mips_mem_rdpipe #(.STAGES(LATENCY - 1)) u_pipe2 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s0_vld2_q),
        .in_exc  (s0_exc2_q),
        .in_dat  (s0_dat2_q),
        .out_vld (valid2),
        .out_exc (excpt2),
        .out_dat (data_out2)
    );

endmodule

// File: tb/tb_mips_mem_pipe.sv
// Scoreboard bench for mips_mem_pipe with DEPTH_LOG2=12, BASE_WADDR=0, LATENCY=2.
module tb_mips_mem_pipe;

    localparam int LAT = 2;

    typedef struct {
        logic        exc;
        bit          known;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1 = 1'b0, req2 = 1'b0;
    logic [29:0] addr1 = '0, addr2 = '0;
    logic [31:0] data_in2 = '0;
    logic [3:0]  we2 = '0;
    logic        valid1, valid2, excpt1, excpt2;
    logic [31:0] data_out1, data_out2;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] model[int];
    bit          known[int];

    mips_mem_pipe #(.DEPTH_LOG2(12), .BASE_WADDR(30'h0), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req1      (req1),
        .addr1     (addr1),
        .valid1    (valid1),
        .data_out1 (data_out1),
        .excpt1    (excpt1),
        .req2      (req2),
        .addr2     (addr2),
        .data_in2  (data_in2),
        .we2       (we2),
        .valid2    (valid2),
        .data_out2 (data_out2),
        .excpt2    (excpt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic exp_t model_read(input logic [29:0] a);
        exp_t e;
        e.cyc = 0;
        if (a[29:12] != '0) begin
            e.exc = 1'b1; e.known = 1'b1; e.dat = '0;
        end else begin
            e.exc   = 1'b0;
            e.known = known.exists(int'(a[11:0])) ? known[int'(a[11:0])] : 1'b0;
            e.dat   = model.exists(int'(a[11:0])) ? model[int'(a[11:0])] : '0;
        end
        return e;
    endfunction

    // Drive one cycle of requests; expectations come from the bench's own memory model.
    task automatic issue(input bit r1, input logic [29:0] a1, input bit r2, input logic [29:0] a2,
                         input logic [31:0] d2, input logic [3:0] be);
        exp_t e1, e2;
        int   i2;
        req1 = r1; addr1 = a1; req2 = r2; addr2 = a2; data_in2 = d2; we2 = be;
        e1 = model_read(a1);
        e2 = model_read(a2);
`ifdef MIPS_MEM_FWD_EN
        if (r2 && be != 0 && a2[29:12] == '0 && a1 == a2) begin
            e1.dat   = merge(e1.dat, d2, be);
            e1.known = e1.known || (be == 4'hF);
        end
`endif
        e1.cyc = cyc + LAT;
        e2.cyc = cyc + LAT;
        if (r1) q1.push_back(e1);
        if (r2) q2.push_back(e2);
        if (r2 && be != 0 && a2[29:12] == '0) begin
            i2        = int'(a2[11:0]);
            model[i2] = merge(e2.dat, d2, be);
            known[i2] = e2.known || (be == 4'hF);
        end
        @(posedge clk);
        #1;
        req1 = 1'b0; req2 = 1'b0; we2 = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid1) begin
            if (q1.size() == 0) chk("p1_unexpected_valid", 64'(valid1), 64'd0);
            else begin
                e = q1.pop_front();
                chk("p1_cycle", 64'(cyc), 64'(e.cyc));
                chk("p1_excpt", 64'(excpt1), 64'(e.exc));
                if (e.known) chk("p1_data", 64'(data_out1), 64'(e.dat));
            end
        end else begin
            chk("p1_idle_zero", 64'({excpt1, data_out1}), 64'd0);
        end
        if (valid2) begin
            if (q2.size() == 0) chk("p2_unexpected_valid", 64'(valid2), 64'd0);
            else begin
                e = q2.pop_front();
                chk("p2_cycle", 64'(cyc), 64'(e.cyc));
                chk("p2_excpt", 64'(excpt2), 64'(e.exc));
                if (e.known) chk("p2_data", 64'(data_out2), 64'(e.dat));
            end
        end else begin
            chk("p2_idle_zero", 64'({excpt2, data_out2}), 64'd0);
        end
    end

    initial begin
        // Requests during reset must be ignored.
        req1 = 1'b1; addr1 = 30'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid1", 64'(valid1), 64'd0);
        chk("rst_valid2", 64'(valid2), 64'd0);
        chk("rst_outs", 64'({excpt1, excpt2, data_out1 | data_out2}), 64'd0);
        req1 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(0, 0, 1, 30'd5, 32'hCAFEF00D, 4'hF);
        issue(1, 30'd5, 0, 0, 0, 0);
        issue(0, 0, 1, 30'd5, 32'h11223344, 4'b0101);
        issue(1, 30'd5, 1, 30'd5, 0, 4'h0);

        issue(0, 0, 1, 30'd0, 32'h12345678, 4'hF);
        issue(1, 30'h1000, 0, 0, 0, 0);
        issue(0, 0, 1, 30'h1000, 32'hDEADBEEF, 4'hF);
        issue(1, 30'd0, 0, 0, 0, 0);

        issue(0, 0, 1, 30'd7, 32'h0, 4'hF);
        issue(1, 30'd7, 1, 30'd7, 32'hAAAAAAAA, 4'hF);
        issue(1, 30'd7, 0, 0, 0, 0);

        issue(0, 0, 1, 30'd1, 32'h0000_1111, 4'hF);
        issue(0, 0, 1, 30'd2, 32'h0000_2222, 4'hF);
        issue(1, 30'd0, 0, 0, 0, 0);
        issue(1, 30'd1, 0, 0, 0, 0);
        issue(1, 30'd2, 0, 0, 0, 0);

        // Write enables with req2 low must not touch memory.
        issue(0, 0, 0, 30'd1, 32'hBADBAD00, 4'hF);
        issue(1, 30'd1, 1, 30'd1, 0, 4'h0);

        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) idle(1);
        chk("drain1", 64'(q1.size()), 64'd0);
        chk("drain2", 64'(q2.size()), 64'd0);

        // In-flight read killed by reset; a write and read sampled under reset are dropped.
        req1 = 1'b1; addr1 = 30'd5;
        @(posedge clk);
        #1;
        rst = 1'b1; req1 = 1'b1; addr1 = 30'd5;
        req2 = 1'b1; addr2 = 30'd2; data_in2 = 32'hFFFF_FFFF; we2 = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0; req1 = 1'b0; req2 = 1'b0; we2 = '0;
        @(negedge clk);
        chk("post_rst_valids", 64'({valid1, valid2}), 64'd0);
        chk("post_rst_excpts", 64'({excpt1, excpt2}), 64'd0);
        chk("post_rst_data", 64'({data_out1, data_out2}), 64'd0);
        issue(1, 30'd2, 1, 30'd5, 0, 4'h0);
        idle(8);

        chk("final_q1_empty", 64'(q1.size()), 64'd0);
        chk("final_q2_empty", 64'(q2.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
